// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes (WASD, ANSI arrow escape
// sequences, 'r' restart) into 2048 game commands and buffers them in a
// small first-word-fall-through FIFO drained with a valid/ready handshake.
module uart_cmd_decoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ESC_TIMEOUT = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic [2:0]                    o_cmd,
  output logic                          o_cmd_valid,
  input  logic                          i_cmd_ready,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(ESC_TIMEOUT);

  localparam logic [2:0] CmdUp      = 3'd0;
  localparam logic [2:0] CmdDown    = 3'd1;
  localparam logic [2:0] CmdLeft    = 3'd2;
  localparam logic [2:0] CmdRight   = 3'd3;
  localparam logic [2:0] CmdRestart = 3'd4;

  localparam logic [7:0] ByteEsc = 8'h1b;
  localparam logic [7:0] ByteCsi = 8'h5b;  // '['

  typedef enum logic [1:0] {
    StIdle,
    StGotEsc,
    StGotCsi
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                dec_valid;
  logic [2:0]          dec_cmd;
  logic                timeout_hit;

  logic [2:0]          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [2:0]          last_q;
  logic                overflow_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                wr_en;

  assign timeout_hit = (timer_q == TimerW'(ESC_TIMEOUT - 1));

  // Decode FSM next state, escape timer and decoded-command strobe.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dec_valid = 1'b0;
    dec_cmd   = CmdUp;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h77, 8'h57: begin dec_valid = 1'b1; dec_cmd = CmdUp;      end // w W
            8'h73, 8'h53: begin dec_valid = 1'b1; dec_cmd = CmdDown;    end // s S
            8'h61, 8'h41: begin dec_valid = 1'b1; dec_cmd = CmdLeft;    end // a A
            8'h64, 8'h44: begin dec_valid = 1'b1; dec_cmd = CmdRight;   end // d D
            8'h72, 8'h52: begin dec_valid = 1'b1; dec_cmd = CmdRestart; end // r R
            ByteEsc:      state_d = StGotEsc;
            default:      ;
          endcase
        end
      end
      StGotEsc: begin
        if (i_rx_valid) begin
          timer_d = '0;
          case (i_rx_data)
            ByteCsi: state_d = StGotCsi;
            ByteEsc: state_d = StGotEsc;
            default: state_d = StIdle;
          endcase
        end else if (timeout_hit) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGotCsi: begin
        if (i_rx_valid) begin
          state_d = StIdle;
          timer_d = '0;
          case (i_rx_data)
            8'h41:   begin dec_valid = 1'b1; dec_cmd = CmdUp;    end // A
            8'h42:   begin dec_valid = 1'b1; dec_cmd = CmdDown;  end // B
            8'h43:   begin dec_valid = 1'b1; dec_cmd = CmdRight; end // C
            8'h44:   begin dec_valid = 1'b1; dec_cmd = CmdLeft;  end // D
            default: ;
          endcase
        end else if (timeout_hit) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Decode FSM state and escape timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && i_cmd_ready;
  // A pop frees the head slot this cycle, so a full FIFO can still accept.
  assign wr_en      = dec_valid && (!fifo_full || pop);

  // FIFO storage; only ever read when occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= dec_cmd;
    end
  end

  // FIFO pointers, occupancy, held head value and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= CmdUp;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= dec_valid && fifo_full && !pop;
    end
  end

  // While empty, keep presenting the most recently consumed command.
  always_comb begin
    o_cmd = fifo_empty ? last_q : mem_q[rd_ptr_q];
  end

  assign o_cmd_valid  = !fifo_empty;
  assign o_overflow   = overflow_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: directed scenarios plus randomized bytes,
// checked every cycle against a queue-based behavioural model.
module tb_uart_cmd_decoder;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 40;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks;
  int n_fail;
  int ovf_total;

  // Behavioural model state.
  int         mq[$];
  logic [7:0] prefix[$];
  int         last_cmd;
  int         exp_ovf;
  int         cyc;
  int         last_cyc;

  uart_cmd_decoder #(
    .FIFO_DEPTH  (Depth),
    .ESC_TIMEOUT (Tmo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_cmd        (cmd),
    .o_cmd_valid  (cmd_valid),
    .i_cmd_ready  (cmd_ready),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command a byte maps to with no escape prefix, or -1 if ignored.
  function automatic int plain_cmd(input logic [7:0] b);
    case (b)
      "w", "W": return 0;
      "s", "S": return 1;
      "a", "A": return 2;
      "d", "D": return 3;
      "r", "R": return 4;
      default:  return -1;
    endcase
  endfunction

  function automatic int arrow_cmd(input logic [7:0] b);
    case (b)
      "A":     return 0;
      "B":     return 1;
      "C":     return 3;
      "D":     return 2;
      default: return -1;
    endcase
  endfunction

  // Reference model: escape prefix as a byte list that expires when the gap
  // between bytes exceeds the timeout; FIFO as a bounded queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      prefix.delete();
      last_cmd = 0;
      exp_ovf  = 0;
      cyc      = 0;
      last_cyc = 0;
    end else begin
      int  c;
      int  sz;
      bit  do_pop;
      c = -1;
      cyc++;
      if (rx_valid) begin
        if (prefix.size() > 0 && (cyc - last_cyc) > int'(Tmo)) prefix.delete();
        last_cyc = cyc;
        if (prefix.size() == 0) begin
          c = plain_cmd(rx_data);
          if (rx_data == 8'h1b) prefix.push_back(rx_data);
        end else if (prefix.size() == 1) begin
          if (rx_data == "[") prefix.push_back(rx_data);
          else if (rx_data != 8'h1b) prefix.delete();
        end else begin
          c = arrow_cmd(rx_data);
          prefix.delete();
        end
      end
      sz      = mq.size();
      do_pop  = (sz > 0) && cmd_ready;
      exp_ovf = 0;
      if (do_pop) last_cmd = mq.pop_front();
      if (c >= 0) begin
        if (sz < int'(Depth) || do_pop) mq.push_back(c);
        else exp_ovf = 1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cmd_valid", int'(cmd_valid), (mq.size() > 0) ? 1 : 0);
      check("cmd", int'(cmd), (mq.size() > 0) ? mq[0] : last_cmd);
      check("fifo_count", int'(fifo_count), mq.size());
      check("overflow", int'(overflow), exp_ovf);
      if (overflow) ovf_total++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [7:0] tbl [16] = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h72, 8'h57, 8'h44, 8'h1b,
                           8'h1b, 8'h5b, 8'h5b, 8'h41, 8'h42, 8'h43, 8'h44, 8'h78};

  initial begin
    int snap;
    int exp_drain [4];
    n_checks  = 0;
    n_fail    = 0;
    ovf_total = 0;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    tick();
    check("reset_cmd", int'(cmd), 0);
    check("reset_valid", int'(cmd_valid), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ovf", int'(overflow), 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Plain keys with the consumer always ready.
    cmd_ready = 1'b1;
    send("w");
    check("t1_w_valid", int'(cmd_valid), 1);
    check("t1_w_cmd", int'(cmd), 0);
    tick();
    check("t1_w_one_cycle", int'(cmd_valid), 0);
    idle(18);
    send("A");
    check("t1_A_cmd", int'(cmd), 2);
    idle(19);
    send("x");
    check("t1_x_ignored", int'(cmd_valid), 0);
    idle(19);
    send("R");
    check("t1_R_cmd", int'(cmd), 4);
    idle(19);

    // Arrow escape sequence.
    send(8'h1b); idle(9); send("["); idle(9); send("C");
    check("t2_right_valid", int'(cmd_valid), 1);
    check("t2_right_cmd", int'(cmd), 3);
    tick();
    check("t2_single", int'(cmd_valid), 0);

    // Timeout: gap of Tmo+1 cycles expires, gap of exactly Tmo still decodes.
    send(8'h1b); idle(9); send("["); idle(Tmo); send("B");
    check("t3_timeout_none", int'(cmd_valid), 0);
    idle(3);
    send(8'h1b); send("["); idle(Tmo - 1); send("B");
    check("t3_boundary_valid", int'(cmd_valid), 1);
    check("t3_boundary_cmd", int'(cmd), 1);
    idle(3);

    // Overflow with the consumer stalled.
    cmd_ready = 1'b0;
    snap = ovf_total;
    for (int i = 0; i < 6; i++) send("d");
    check("t4_count_full", int'(fifo_count), 4);
    tick();
    check("t4_ovf_pulses", ovf_total - snap, 2);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_cmd", int'(cmd), 3);
      tick();
    end
    check("t4_drained", int'(fifo_count), 0);
    check("t4_hold_cmd", int'(cmd), 3);

    // Push and pop together while full.
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send("a");
    check("t5_full", int'(fifo_count), 4);
    cmd_ready = 1'b1;
    send("w");
    cmd_ready = 1'b0;
    check("t5_count_same", int'(fifo_count), 4);
    check("t5_no_ovf", int'(overflow), 0);
    exp_drain = '{2, 2, 2, 0};
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_cmd", int'(cmd), exp_drain[i]);
      tick();
    end
    check("t5_empty", int'(cmd_valid), 0);

    // Mid-operation reset discards the queue and the partial sequence.
    cmd_ready = 1'b0;
    send("w"); send(8'h1b); send("[");
    rst = 1'b1;
    tick();
    check("t6_rst_cmd", int'(cmd), 0);
    check("t6_rst_valid", int'(cmd_valid), 0);
    check("t6_rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    tick();
    send("A");
    check("t6_A_plain_left", int'(cmd), 2);
    check("t6_A_count", int'(fifo_count), 1);
    cmd_ready = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      cmd_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 45) send(tbl[$urandom_range(0, 15)]);
      else if (r < 97) tick();
      else idle($urandom_range(Tmo - 2, Tmo + 2));
    end
    cmd_ready = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
